// File: rtl/cfg_pkg.sv
// Shared constants and FSM encoding for the configuration bitstream loader.
package cfg_pkg;
  localparam int CFG_BITS = 4416;
  localparam int WORD_W   = 32;
  localparam int NWORDS   = (CFG_BITS + WORD_W - 1) / WORD_W;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CRC  = 2'd2,
    ST_FIN  = 2'd3
  } ld_state_e;
endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16-CCITT, MSB-first, no reflection, no final XOR.
module crc16_serial
  import cfg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);
  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic        fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[15] ^ bit_i;
    if (clr_i) begin
      crc_d = CRC16_INIT;
    end else if (en_i) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;
endmodule

// File: rtl/cfg_bitstream_loader.sv
// Serializes a word-wide bitstream LSB-first into the fabric configuration chain
// and checks the trailing CRC word. A word moves on wr_valid & wr_ready in the same cycle.
module cfg_bitstream_loader #(
  parameter int CFG_BITS = cfg_pkg::CFG_BITS,
  parameter int WORD_W   = cfg_pkg::WORD_W
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              prog_in,
  output logic              prog_en,
  output logic              busy,
  output logic              done,
  output logic              crc_ok
);
  import cfg_pkg::*;

  localparam int N_WORDS = (CFG_BITS + WORD_W - 1) / WORD_W;
  localparam int BCW     = $clog2(CFG_BITS + 1);
  localparam int WCW     = $clog2(N_WORDS + 1);
  localparam int SCW     = $clog2(WORD_W + 1);

  localparam logic [BCW-1:0] LAST_BIT  = BCW'(CFG_BITS - 1);
  localparam logic [WCW-1:0] WORDS_MAX = WCW'(N_WORDS);
  localparam logic [SCW-1:0] SR_FULL   = SCW'(WORD_W);

  ld_state_e         state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [SCW-1:0]    sr_cnt_q, sr_cnt_d;
  logic [WORD_W-1:0] hr_q, hr_d;
  logic              hr_vld_q, hr_vld_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic              prog_in_q, prog_in_d;
  logic              prog_en_q, prog_en_d;
  logic              crc_ok_q, crc_ok_d;

  logic              accept;
  logic              sr_shift;
  logic              sr_free;
  logic              crc_clr;
  logic              crc_en;
  logic [15:0]       crc_val;

  assign wr_ready = ((state_q == ST_LOAD) && !hr_vld_q && (word_cnt_q < WORDS_MAX)) ||
                    (state_q == ST_CRC);
  assign accept   = wr_valid & wr_ready;
  assign sr_shift = (state_q == ST_LOAD) && (sr_cnt_q != '0);
  // SR is reusable next cycle when it is empty or is giving up its last bit now.
  assign sr_free  = (sr_cnt_q <= SCW'(1));

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    sr_cnt_d   = sr_cnt_q;
    hr_d       = hr_q;
    hr_vld_d   = hr_vld_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    prog_in_d  = 1'b0;
    prog_en_d  = 1'b0;
    crc_ok_d   = crc_ok_q;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d    = ST_LOAD;
          crc_ok_d   = 1'b0;
          crc_clr    = 1'b1;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          sr_cnt_d   = '0;
          hr_vld_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (sr_shift) begin
          prog_in_d = sr_q[0];
          prog_en_d = 1'b1;
          crc_en    = 1'b1;
          sr_d      = sr_q >> 1;
          sr_cnt_d  = sr_cnt_q - SCW'(1);
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
        if (sr_free && hr_vld_q) begin
          sr_d     = hr_q;
          sr_cnt_d = SR_FULL;
          hr_vld_d = 1'b0;
        end else if (accept) begin
          word_cnt_d = word_cnt_q + WCW'(1);
          if (sr_free) begin
            sr_d     = wr_data;
            sr_cnt_d = SR_FULL;
          end else begin
            hr_d     = wr_data;
            hr_vld_d = 1'b1;
          end
        end
        // Any bits of the final word beyond the chain length are dropped here.
        if (sr_shift && (bit_cnt_q == LAST_BIT)) begin
          state_d  = ST_CRC;
          sr_cnt_d = '0;
          hr_vld_d = 1'b0;
        end
      end
      ST_CRC: begin
        if (accept) begin
          crc_ok_d = (wr_data[15:0] == crc_val);
          state_d  = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      prog_in_d  = 1'b0;
      prog_en_d  = 1'b0;
      crc_en     = 1'b0;
      sr_cnt_d   = '0;
      hr_vld_d   = 1'b0;
      bit_cnt_d  = '0;
      word_cnt_d = '0;
      crc_ok_d   = 1'b0;
    end
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      sr_cnt_q   <= '0;
      hr_q       <= '0;
      hr_vld_q   <= 1'b0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      prog_in_q  <= 1'b0;
      prog_en_q  <= 1'b0;
      crc_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      sr_cnt_q   <= sr_cnt_d;
      hr_q       <= hr_d;
      hr_vld_q   <= hr_vld_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      prog_in_q  <= prog_in_d;
      prog_en_q  <= prog_en_d;
      crc_ok_q   <= crc_ok_d;
    end
  end

  crc16_serial u_crc (
    .clk_i  (prog_clk),
    .rst_ni (prog_rst_n),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .bit_i  (sr_q[0]),
    .crc_o  (crc_val)
  );

  assign prog_in = prog_in_q;
  assign prog_en = prog_en_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_FIN);
  assign crc_ok  = crc_ok_q;
endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Directed bench for cfg_bitstream_loader: full-size instance plus a 70-bit instance.
module tb_cfg_bitstream_loader;
  localparam int NB = 4416;
  localparam int NW = 138;
  localparam int SB = 70;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ready, prog_in, prog_en, busy, done, crc_ok;
  logic        s_start = 1'b0, s_abort = 1'b0, s_wr_valid = 1'b0;
  logic [31:0] s_wr_data = '0;
  logic        s_wr_ready, s_prog_in, s_prog_en, s_busy, s_done, s_crc_ok;

  int checks = 0;
  int errors = 0;
  bit stop_drv = 1'b0;

  logic [31:0] img [0:NW-1];
  logic [31:0] s_img [0:2];
  logic        exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  cfg_bitstream_loader u_dut (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .abort(abort),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .prog_in(prog_in), .prog_en(prog_en), .busy(busy), .done(done), .crc_ok(crc_ok)
  );

  cfg_bitstream_loader #(.CFG_BITS(SB), .WORD_W(32)) u_small (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(s_start), .abort(s_abort),
    .wr_data(s_wr_data), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready),
    .prog_in(s_prog_in), .prog_en(s_prog_en), .busy(s_busy), .done(s_done), .crc_ok(s_crc_ok)
  );

  // chain-side monitor
  logic obs_q[$];
  logic s_obs_q[$];
  int   en_total = 0, en_runs = 0, done_cycles = 0;
  int   s_en_total = 0, s_done_cycles = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (prog_en) begin
      obs_q.push_back(prog_in);
      en_total <= en_total + 1;
      if (!prev_en) en_runs <= en_runs + 1;
    end
    prev_en <= prog_en;
    if (done) done_cycles <= done_cycles + 1;
    if (s_prog_en) begin
      s_obs_q.push_back(s_prog_in);
      s_en_total <= s_en_total + 1;
    end
    if (s_done) s_done_cycles <= s_done_cycles + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic img_bit(input int i);
    logic [31:0] w;
    w = img[i / 32];
    return w[i % 32];
  endfunction

  function automatic logic s_img_bit(input int i);
    logic [31:0] w;
    w = s_img[i / 32];
    return w[i % 32];
  endfunction

  function automatic logic [15:0] crc_img(input int nbits);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < nbits; i++) c = crc_step(c, img_bit(i));
    return c;
  endfunction

  task automatic fill_img(input int mode);
    for (int i = 0; i < NW; i++) begin
      case (mode)
        0:       img[i] = 32'hA5A5_A5A5;
        1:       img[i] = 32'h3C96_0F1E ^ (32'(i) * 32'h0001_0003);
        default: img[i] = {16'(i), ~16'(i)};
      endcase
    end
    exp_q.delete();
    for (int i = 0; i < NB; i++) exp_q.push_back(img_bit(i));
  endtask

  // driver: present one word, hold until accepted (optionally after a random idle gap)
  task automatic drive_word(input logic [31:0] w, input bit gaps);
    int guard;
    if (gaps && ($urandom_range(1, 0) == 1)) begin
      wr_valid = 1'b0;
      repeat ($urandom_range(64, 1)) @(negedge clk);
    end
    wr_data  = w;
    wr_valid = 1'b1;
    guard    = 0;
    while (!wr_ready && !stop_drv && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: wr_ready=0 for %0d cycles, required 1", guard);
    end
    if (!stop_drv) @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic run_load(input bit gaps, input bit flip);
    logic [15:0] c;
    int guard;
    c = crc_img(NB) ^ {15'd0, flip};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NW; i++) drive_word(img[i], gaps);
    drive_word({16'hDEAD, c}, gaps);
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL load_end: busy=%0b, required 0", busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_bits(input string name, input int base, input int n);
    int mism;
    mism = 0;
    for (int i = 0; i < n; i++)
      if ((base + i) >= obs_q.size() || obs_q[base + i] !== exp_q[i]) mism++;
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL %s: %0d of %0d bits differ from the bitstream model, required 0", name, mism, n);
    end
  endtask

  task automatic test_reset;
    logic [15:0] c;
    logic [7:0]  ch;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_ready, prog_in, prog_en, busy, done, crc_ok} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 000000",
               {wr_ready, prog_in, prog_en, busy, done, crc_ok});
    end
    c = 16'hFFFF;
    for (int k = 0; k < 9; k++) begin
      ch = 8'h31 + 8'(k);
      for (int b = 7; b >= 0; b--) c = crc_step(c, ch[b]);
    end
    checks++;
    if (c !== 16'h29B1) begin
      errors++;
      $display("FAIL crc_model_known_answer: got %h, required 29b1", c);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_and_latency;
    wr_data = 32'h0000_0005;
    wr_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++; $display("FAIL idle_not_ready: wr_ready=%b, required 0", wr_ready);
    end
    wr_valid = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, wr_ready} !== 2'b00) begin
      errors++; $display("FAIL start_abort_idle: busy,wr_ready=%b, required 00", {busy, wr_ready});
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, wr_ready} !== 2'b11) begin
      errors++; $display("FAIL start_latency: busy,wr_ready=%b, required 11", {busy, wr_ready});
    end
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    checks++;
    if (prog_en !== 1'b0) begin
      errors++; $display("FAIL first_word_t1: prog_en=%b, required 0", prog_en);
    end
    @(negedge clk);
    checks++;
    if ({prog_en, prog_in} !== 2'b11) begin
      errors++; $display("FAIL first_word_t2: prog_en,prog_in=%b, required 11", {prog_en, prog_in});
    end
    @(negedge clk);
    checks++;
    if ({prog_en, prog_in} !== 2'b10) begin
      errors++; $display("FAIL second_bit: prog_en,prog_in=%b, required 10", {prog_en, prog_in});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, prog_en} !== 2'b00) begin
      errors++; $display("FAIL early_abort: busy,prog_en=%b, required 00", {busy, prog_en});
    end
    @(negedge clk);
  endtask

  task automatic test_gapless;
    int base, rbase, dbase, ob;
    logic [3:0] first4;
    fill_img(0);
    base = en_total; rbase = en_runs; dbase = done_cycles; ob = obs_q.size();
    run_load(1'b0, 1'b0);
    checks++;
    if (en_total - base != NB) begin
      errors++; $display("FAIL gapless_en_count: %0d cycles, required %0d", en_total - base, NB);
    end
    checks++;
    if (en_runs - rbase != 1) begin
      errors++; $display("FAIL gapless_en_runs: %0d runs, required 1", en_runs - rbase);
    end
    check_bits("gapless_bits", ob, NB);
    first4 = (obs_q.size() >= ob + 4) ?
             {obs_q[ob + 3], obs_q[ob + 2], obs_q[ob + 1], obs_q[ob]} : 4'bxxxx;
    checks++;
    if (first4 !== 4'b0101) begin
      errors++; $display("FAIL gapless_first_bits: got %b, required 0101", first4);
    end
    checks++;
    if (done_cycles - dbase != 1) begin
      errors++; $display("FAIL gapless_done_pulse: %0d cycles, required 1", done_cycles - dbase);
    end
    checks++;
    if (crc_ok !== 1'b1) begin
      errors++; $display("FAIL gapless_crc_ok: got %b, required 1", crc_ok);
    end
  endtask

  task automatic test_gaps_bad_crc;
    int base, dbase, ob;
    fill_img(0);
    base = en_total; dbase = done_cycles; ob = obs_q.size();
    run_load(1'b1, 1'b1);
    checks++;
    if (en_total - base != NB) begin
      errors++; $display("FAIL gaps_en_count: %0d cycles, required %0d", en_total - base, NB);
    end
    check_bits("gaps_bits", ob, NB);
    checks++;
    if (done_cycles - dbase != 1) begin
      errors++; $display("FAIL gaps_done_pulse: %0d cycles, required 1", done_cycles - dbase);
    end
    checks++;
    if (crc_ok !== 1'b0) begin
      errors++; $display("FAIL bad_crc_detect: crc_ok=%b, required 0", crc_ok);
    end
  endtask

  task automatic test_short_bitstream;
    int base, dbase, ob, guard, mism;
    logic [15:0] c;
    s_img[0] = 32'h1234_5678;
    s_img[1] = 32'hCAFE_F00D;
    s_img[2] = 32'hFFFF_FFD2;
    c = 16'hFFFF;
    for (int i = 0; i < SB; i++) c = crc_step(c, s_img_bit(i));
    base = s_en_total; dbase = s_done_cycles; ob = s_obs_q.size();
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_wr_data  = (i < 3) ? s_img[i] : {16'hFFFF, c};
      s_wr_valid = 1'b1;
      guard = 0;
      while (!s_wr_ready && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 1000) begin
        checks++; errors++;
        $display("FAIL short_handshake: wr_ready=0 for %0d cycles, required 1", guard);
      end
      @(negedge clk);
      s_wr_valid = 1'b0;
    end
    guard = 0;
    while (s_busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    checks++;
    if (s_en_total - base != SB) begin
      errors++; $display("FAIL short_en_count: %0d cycles, required %0d", s_en_total - base, SB);
    end
    mism = 0;
    for (int i = 0; i < SB; i++)
      if ((ob + i) >= s_obs_q.size() || s_obs_q[ob + i] !== s_img_bit(i)) mism++;
    checks++;
    if (mism != 0) begin
      errors++; $display("FAIL short_bits: %0d bits differ, required 0", mism);
    end
    checks++;
    if ({s_crc_ok, 1'b0} !== 2'b10 || s_done_cycles - dbase != 1) begin
      errors++;
      $display("FAIL short_crc_done: crc_ok=%b done_cycles=%0d, required 1 and 1",
               s_crc_ok, s_done_cycles - dbase);
    end
  endtask

  task automatic test_abort;
    int base, dbase, ob;
    fill_img(1);
    base = en_total; dbase = done_cycles; ob = obs_q.size();
    stop_drv = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fork
      begin
        for (int i = 0; i < NW && !stop_drv; i++) drive_word(img[i], 1'b0);
      end
      begin
        int wguard;
        wguard = 0;
        while ((en_total - base) < 1000 && wguard < 5000) begin
          @(posedge clk);
          wguard++;
        end
        @(negedge clk);
        abort = 1'b1;
        stop_drv = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
    join
    checks++;
    if ({prog_en, busy, wr_ready} !== 3'b000) begin
      errors++;
      $display("FAIL abort_outputs: prog_en,busy,wr_ready=%b, required 000", {prog_en, busy, wr_ready});
    end
    @(negedge clk);
    stop_drv = 1'b0;
    checks++;
    if (en_total - base != 1001) begin
      errors++; $display("FAIL abort_bit_count: %0d bits, required 1001", en_total - base);
    end
    check_bits("abort_prefix_bits", ob, 1001);
    checks++;
    if (done_cycles != dbase || crc_ok !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done_cycles=%0d crc_ok=%b, required 0 and 0", done_cycles - dbase, crc_ok);
    end
    base = en_total; ob = obs_q.size();
    run_load(1'b0, 1'b0);
    check_bits("reload_after_abort_bits", ob, NB);
    checks++;
    if (crc_ok !== 1'b1 || en_total - base != NB) begin
      errors++;
      $display("FAIL reload_after_abort: crc_ok=%b en=%0d, required 1 and %0d", crc_ok, en_total - base, NB);
    end
  endtask

  task automatic test_reset_midload;
    int base, ob;
    fill_img(2);
    base = en_total;
    stop_drv = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fork
      begin
        for (int i = 0; i < NW && !stop_drv; i++) drive_word(img[i], 1'b0);
      end
      begin
        int wguard;
        wguard = 0;
        while ((en_total - base) < 2000 && wguard < 8000) begin
          @(posedge clk);
          wguard++;
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        stop_drv = 1'b1;
        #1;
        checks++;
        if ({wr_ready, prog_in, prog_en, busy, done, crc_ok} !== 6'b0) begin
          errors++;
          $display("FAIL reset_midload_outputs: got %b, required 000000",
                   {wr_ready, prog_in, prog_en, busy, done, crc_ok});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    @(negedge clk);
    stop_drv = 1'b0;
    base = en_total; ob = obs_q.size();
    run_load(1'b0, 1'b0);
    check_bits("reload_after_reset_bits", ob, NB);
    checks++;
    if (crc_ok !== 1'b1 || en_total - base != NB) begin
      errors++;
      $display("FAIL reload_after_reset: crc_ok=%b en=%0d, required 1 and %0d", crc_ok, en_total - base, NB);
    end
  endtask

  initial begin
    test_reset();
    test_idle_and_latency();
    test_gapless();
    test_gaps_bad_crc();
    test_short_bitstream();
    test_abort();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
